// File: rtl/pcpo_pkg.sv
// Shared types and constants for the round-robin popcount arbiter.
// Holds the arbiter state encoding, default timeout, timeout result and a clog2 helper.
package pcpo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int DEF_TIMEOUT = 40;

  // All-ones result reported on an aborted job; sliced down to RES_W by users.
  localparam logic [31:0] TIMEOUT_RES = '1;

  function automatic int pcpo_clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/pcpo_rr_pick.sv
// Combinational round-robin picker: first set request bit after last_grant, with wrap-around.
module pcpo_rr_pick
  import pcpo_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int GW    = pcpo_clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GW-1:0]    last_grant,
  output logic             found,
  output logic [GW-1:0]    idx
);

  logic [GW:0] cand;

  // Walk from the farthest candidate to the nearest so the nearest set bit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = {1'b0, last_grant} + (GW+1)'(k);
      if (cand >= (GW+1)'(N_REQ)) cand = cand - (GW+1)'(N_REQ);
      if (req[cand[GW-1:0]]) begin
        found = 1'b1;
        idx   = cand[GW-1:0];
      end
    end
  end

endmodule

// File: rtl/pcpo_arb.sv
// Round-robin arbiter sharing one popcount unit among N_REQ requesters.
// Latches the granted operand, launches the unit, waits with a timeout guard and acks the result.
module pcpo_arb
  import pcpo_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int WIDTH   = 16,
  parameter  int RES_W   = 5,
  parameter  int TIMEOUT = DEF_TIMEOUT,
  localparam int GW      = pcpo_clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] data_in,
  output logic [N_REQ-1:0]       ack,
  output logic [RES_W-1:0]       res_out,
  output logic                   err,
  output logic                   busy,
  output logic [GW-1:0]          grant_id,
  output logic [WIDTH-1:0]       pc_A,
  output logic                   pc_start,
  input  logic [RES_W-1:0]       pc_resultado,
  input  logic                   pc_pronto
);

  localparam int TW = pcpo_clog2(TIMEOUT + 1);

  state_t             state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [GW-1:0]      last_grant_q, last_grant_d;
  logic [GW-1:0]      grant_id_q, grant_id_d;
  logic [WIDTH-1:0]   pc_a_q, pc_a_d;
  logic [RES_W-1:0]   res_q, res_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               start_q, start_d;

  logic               pick_found;
  logic [GW-1:0]      pick_idx;

  pcpo_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req        (req),
    .last_grant (last_grant_q),
    .found      (pick_found),
    .idx        (pick_idx)
  );

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    pc_a_d       = pc_a_q;
    res_d        = res_q;
    ack_d        = '0;
    err_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_id_d = pick_idx;
          pc_a_d     = data_in[int'(pick_idx)*WIDTH +: WIDTH];
          state_d    = LAUNCH;
        end
      end
      LAUNCH: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (timer_q != {TW{1'b1}}) timer_d = timer_q + TW'(1);
        // A pronto seen at timer==0 may still belong to the previous job.
        if (timer_q != '0 && pc_pronto) begin
          res_d             = pc_resultado;
          ack_d[grant_id_q] = 1'b1;
          state_d           = DONE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          res_d             = TIMEOUT_RES[RES_W-1:0];
          err_d             = 1'b1;
          ack_d[grant_id_q] = 1'b1;
          state_d           = DONE;
        end
      end
      DONE: begin
        last_grant_d = grant_id_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d != IDLE);
    start_d = (state_d == LAUNCH);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      last_grant_q <= GW'(N_REQ - 1);
      grant_id_q   <= '0;
      pc_a_q       <= '0;
      res_q        <= '0;
      ack_q        <= '0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      start_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      pc_a_q       <= pc_a_d;
      res_q        <= res_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      start_q      <= start_d;
    end
  end

  assign ack      = ack_q;
  assign res_out  = res_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign grant_id = grant_id_q;
  assign pc_A     = pc_a_q;
  assign pc_start = start_q;

endmodule
